// File: rtl/bist_pkg.sv
// Shared BIST definitions: sequencer states, PRPG width/taps and the PRPG step function.
// Pure declarations; no timing or flow control of its own.
package bist_pkg;

    localparam int LFSR_WIDTH = 16;
    localparam int CNT_WIDTH  = 16;

    // Taps at bits 15,13,12,10 realise x^16+x^14+x^13+x^11+1 in left-shifting Fibonacci form.
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        UNLOAD  = 3'd4,
        COMPARE = 3'd5,
        DONE    = 3'd6
    } bist_state_t;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] s);
        return {s[LFSR_WIDTH-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bist_if.sv
// Scan-side and status-side signals of the BIST sequencer.
// master = sequencer, slave = test access logic plus chain/compactor.
interface bist_if;
    import bist_pkg::*;

    logic                 start;
    logic                 pass_nfail;
    logic                 scan_en;
    logic                 scan_in;
    logic                 misr_reset;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CNT_WIDTH-1:0] pattern_cnt;

    modport master (
        input  start, pass_nfail,
        output scan_en, scan_in, misr_reset, busy, done, pass, pattern_cnt
    );

    modport slave (
        output start, pass_nfail,
        input  scan_en, scan_in, misr_reset, busy, done, pass, pattern_cnt
    );

endinterface

// File: rtl/bist_lfsr_prpg.sv
// 16-bit Fibonacci PRPG: load has priority over advance; otherwise holds.
// Single-cycle update; no flow control.
module lfsr_prpg
    import bist_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] seed,
    input  logic                  advance,
    output logic [LFSR_WIDTH-1:0] state
);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= '0;
        end else if (load) begin
            state <= seed;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/bist_controller.sv
// BIST sequencer: PRPG scan-in, scan_en/capture timing, compactor clear and pass/fail latch.
// Start-to-done 1 + NUM_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles; start ignored while busy.
module bist_controller
    import bist_pkg::*;
#(
    parameter int                    CHAIN_LEN    = 32,
    parameter int                    NUM_PATTERNS = 100,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED    = 16'hACE1
) (
    input  logic     clock,
    input  logic     reset,
    bist_if.master   bus
);

    localparam int SW = $clog2(CHAIN_LEN);

    bist_state_t           state, next_state;
    logic [SW-1:0]         shift_cnt;
    logic [CNT_WIDTH-1:0]  pattern_cnt_q;
    logic                  pass_q;
    logic [LFSR_WIDTH-1:0] lfsr_state;
    logic                  lfsr_unused;
    logic                  shift_last, last_pattern;
    logic                  scan_en_d, misr_reset_d, busy_d, done_d;

    assign shift_last   = (shift_cnt == SW'(CHAIN_LEN - 1));
    assign last_pattern = ((pattern_cnt_q + CNT_WIDTH'(1)) == CNT_WIDTH'(NUM_PATTERNS));

    lfsr_prpg u_prpg (
        .clock   (clock),
        .reset   (reset),
        .load    (misr_reset_d),
        .seed    (LFSR_SEED),
        .advance (scan_en_d),
        .state   (lfsr_state)
    );

    // Only the MSB feeds the chain; the rest of the register is internal to the PRPG.
    assign lfsr_unused = ^lfsr_state[LFSR_WIDTH-2:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            shift_cnt     <= '0;
            pattern_cnt_q <= '0;
            pass_q        <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                INIT: begin
                    shift_cnt     <= '0;
                    pattern_cnt_q <= '0;
                    pass_q        <= 1'b0;
                end
                SHIFT, UNLOAD: shift_cnt <= shift_last ? '0 : shift_cnt + 1'b1;
                CAPTURE:       pattern_cnt_q <= pattern_cnt_q + 1'b1;
                COMPARE:       pass_q <= bus.pass_nfail;
                default:       ;
            endcase
        end
    end

    always_comb begin
        next_state   = state;
        scan_en_d    = 1'b0;
        misr_reset_d = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        case (state)
            IDLE: if (bus.start) next_state = INIT;
            INIT: begin
                misr_reset_d = 1'b1;
                busy_d       = 1'b1;
                next_state   = SHIFT;
            end
            SHIFT: begin
                scan_en_d = 1'b1;
                busy_d    = 1'b1;
                if (shift_last) next_state = CAPTURE;
            end
            CAPTURE: begin
                busy_d     = 1'b1;
                next_state = last_pattern ? UNLOAD : SHIFT;
            end
            UNLOAD: begin
                scan_en_d = 1'b1;
                busy_d    = 1'b1;
                if (shift_last) next_state = COMPARE;
            end
            COMPARE: begin
                busy_d     = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done_d = 1'b1;
                if (bus.start) next_state = INIT;
            end
            default: next_state = IDLE;
        endcase
    end

    assign bus.scan_en     = scan_en_d;
    assign bus.scan_in     = lfsr_state[LFSR_WIDTH-1];
    assign bus.misr_reset  = misr_reset_d;
    assign bus.busy        = busy_d;
    assign bus.done        = done_d;
    assign bus.pass        = pass_q;
    assign bus.pattern_cnt = pattern_cnt_q;

endmodule
